// File: rtl/icache_refill_if.sv
// icache_refill_if: groups the cache-side miss/line signals and the
// instruction-memory read port of the refill engine.
//   slave  : the refill engine's view (miss request and memory data in,
//            line and memory request out)
//   master : the environment's view (cache plus instruction memory)
interface icache_refill_if;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         busy;
    logic [127:0] line_data;
    logic [31:0]  line_addr;
    logic         line_valid;
    logic         refill_err;
    logic         mem_rd;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_rdata;
    logic         mem_ack;

    modport slave (
        input  miss_req, miss_addr, mem_rdata, mem_ack,
        output busy, line_data, line_addr, line_valid, refill_err,
               mem_rd, mem_addr
    );

    modport master (
        output miss_req, miss_addr, mem_rdata, mem_ack,
        input  busy, line_data, line_addr, line_valid, refill_err,
               mem_rd, mem_addr
    );
endinterface

// File: rtl/icache_refill.sv
// icache_refill: fetches the four words of a missing 16-byte instruction line
// in order 0..3, packs them into a 128-bit line (word k at [32k+31:32k]) and
// pulses line_valid for one cycle. A watchdog aborts the refill with a
// one-cycle refill_err pulse after TIMEOUT consecutive cycles without mem_ack.
//
// Ports:
//   clock  - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - icache_refill_if.slave: miss_req/miss_addr in, busy/line_* and
//            refill_err out, mem_rd/mem_addr out, mem_rdata/mem_ack in
//
// State | Meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for miss_req
// FETCH | reading word k of the line, watchdog counting idle cycles
// DONE  | line complete, line_valid high for this one cycle
module icache_refill #(
    parameter int TIMEOUT = 255
) (
    input  logic          clock,
    input  logic          reset,
    icache_refill_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [15:0] WD_MAX  = 16'(TIMEOUT);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    logic [1:0]   state;
    logic [1:0]   k;
    logic [15:0]  wd;
    logic [31:0]  base;
    logic         busy_q;
    logic         line_valid_q;
    logic         refill_err_q;
    logic         mem_rd_q;
    logic [31:0]  mem_addr_q;
    logic [127:0] line_data_q;
    logic [31:0]  line_addr_q;

    // Asserted in the TIMEOUT-th consecutive ack-less FETCH cycle.
    logic wd_expire;
    assign wd_expire = (wd == WD_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            k            <= 2'd0;
            wd           <= 16'd0;
            base         <= 32'd0;
            busy_q       <= 1'b0;
            line_valid_q <= 1'b0;
            refill_err_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            line_data_q  <= 128'd0;
            line_addr_q  <= 32'd0;
        end else begin
            line_valid_q <= 1'b0;
            refill_err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.miss_req) begin
                        base       <= bus.miss_addr & 32'hFFFF_FFF0;
                        mem_addr_q <= bus.miss_addr & 32'hFFFF_FFF0;
                        k          <= 2'd0;
                        wd         <= 16'd0;
                        mem_rd_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        line_data_q[{k, 5'b00000} +: 32] <= bus.mem_rdata;
                        k  <= k + 2'd1;
                        wd <= 16'd0;
                        if (k == 2'd3) begin
                            // mem_addr stays on the last word once the line is in
                            state        <= S_DONE;
                            mem_rd_q     <= 1'b0;
                            line_valid_q <= 1'b1;
                            line_addr_q  <= base;
                        end else begin
                            mem_addr_q <= mem_addr_q + 32'd4;
                        end
                    end else if (wd_expire) begin
                        wd           <= WD_MAX;
                        state        <= S_IDLE;
                        mem_rd_q     <= 1'b0;
                        busy_q       <= 1'b0;
                        refill_err_q <= 1'b1;
                    end else begin
                        wd <= wd + 16'd1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    busy_q   <= 1'b0;
                    mem_rd_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.line_valid = line_valid_q;
    assign bus.refill_err = refill_err_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.line_data  = line_data_q;
    assign bus.line_addr  = line_addr_q;
endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill. Expected lines are queued when a miss is
// issued and popped by a monitor when line_valid pulses.
module tb_icache_refill;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   lv_pulses  = 0;
    int   err_pulses = 0;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
    } line_t;
    line_t exp_q[$];

    icache_refill_if bus ();

    icache_refill #(.TIMEOUT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (bus.refill_err === 1'b1) err_pulses++;
        if (bus.line_valid === 1'b1) begin
            line_t e;
            lv_pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_line_valid", 128'd1, 128'd0);
            end else begin
                e = exp_q.pop_front();
                check("line_addr", bus.line_addr, e.addr);
                check("line_data", bus.line_data, e.data);
            end
        end
    end

    task automatic cycle();
        @(negedge clock);
    endtask

    // Issue a miss at the current negedge; returns the cycle count before the
    // accepting edge and leaves us at the negedge of FETCH cycle 1.
    task automatic launch(input logic [31:0] a, output int acc);
        acc = cyc;
        bus.miss_req  = 1'b1;
        bus.miss_addr = a;
        cycle();
        bus.miss_req = 1'b0;
        check("busy_after_miss", bus.busy, 1'b1);
    endtask

    // Serve the four words with `waits` idle cycles before each ack. Ends at
    // the negedge of the DONE cycle.
    task automatic do_fetch(input logic [31:0] base, input logic [127:0] line,
                            input int waits, input bit intrude);
        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < waits; w++) begin
                bus.mem_ack = 1'b0;
                check($sformatf("wait_addr_w%0d", i), bus.mem_addr, base + 32'(4 * i));
                cycle();
            end
            if (intrude && i == 1) begin
                bus.miss_req  = 1'b1;
                bus.miss_addr = 32'h0000_2000;
            end
            if (intrude && i == 2) bus.miss_req = 1'b0;
            check($sformatf("mem_rd_w%0d", i), bus.mem_rd, 1'b1);
            check($sformatf("mem_addr_w%0d", i), bus.mem_addr, base + 32'(4 * i));
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = line[32*i +: 32];
            cycle();
        end
        bus.mem_ack  = 1'b0;
        bus.miss_req = 1'b0;
    endtask

    initial begin
        int acc;
        logic [127:0] l1, l2, l3, l5, l6;
        bus.miss_req  = 1'b0;
        bus.miss_addr = 32'd0;
        bus.mem_rdata = 32'd0;
        bus.mem_ack   = 1'b0;
        l1 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        l2 = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        l3 = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        l5 = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
        l6 = {32'h6666_000C, 32'h6666_0008, 32'h6666_0004, 32'h6666_0000};

        // reset values
        cycle(); cycle();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_mem_rd", bus.mem_rd, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_line_data", bus.line_data, 128'd0);
        check("rst_line_addr", bus.line_addr, 32'd0);
        check("rst_pulses", {bus.line_valid, bus.refill_err}, 2'b00);
        reset = 1'b0;
        cycle();

        // 1: basic refill, fastest timing
        exp_q.push_back('{addr: 32'h0000_1230, data: l1});
        launch(32'h0000_1234, acc);
        do_fetch(32'h0000_1230, l1, 0, 1'b0);
        check("t1_line_valid", bus.line_valid, 1'b1);
        check("t1_latency", 32'(cyc - acc), 32'd5);
        cycle();
        check("t1_busy_low", bus.busy, 1'b0);
        check("t1_lv_one_cycle", bus.line_valid, 1'b0);

        // 2: two wait states per word
        exp_q.push_back('{addr: 32'h0000_1230, data: l2});
        launch(32'h0000_123C, acc);
        do_fetch(32'h0000_1230, l2, 2, 1'b0);
        check("t2_line_valid", bus.line_valid, 1'b1);
        check("t2_latency", 32'(cyc - acc), 32'd13);
        cycle();

        // 3: miss_req during FETCH is ignored
        exp_q.push_back('{addr: 32'h0000_1230, data: l3});
        launch(32'h0000_1230, acc);
        do_fetch(32'h0000_1230, l3, 0, 1'b1);
        check("t3_line_valid", bus.line_valid, 1'b1);
        cycle();
        check("t3_busy_low", bus.busy, 1'b0);
        cycle();
        check("t3_no_second_fetch", {bus.busy, bus.mem_rd}, 2'b00);

        // 4: watchdog abort with TIMEOUT=4 after word 0
        launch(32'h0000_5000, acc);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        cycle();
        bus.mem_ack = 1'b0;
        check("t4_addr_w1", bus.mem_addr, 32'h0000_5004);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("t4_waiting_%0d", i), {bus.busy, bus.refill_err, bus.mem_rd}, 3'b101);
        end
        cycle();
        check("t4_err_pulse", bus.refill_err, 1'b1);
        check("t4_busy_low", {bus.busy, bus.mem_rd, bus.line_valid}, 3'b000);
        check("t4_word0_kept", bus.line_data[31:0], 32'hDEAD_BEEF);
        cycle();
        check("t4_err_one_cycle", bus.refill_err, 1'b0);

        // 5: reset after the second ack, then a fresh refill
        launch(32'h0000_3000, acc);
        for (int i = 0; i < 2; i++) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'h7777_0000 + 32'(i);
            cycle();
        end
        bus.mem_ack = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("t5_busy", bus.busy, 1'b0);
        check("t5_mem_rd", bus.mem_rd, 1'b0);
        check("t5_line_data", bus.line_data, 128'd0);
        check("t5_pulses", {bus.line_valid, bus.refill_err}, 2'b00);
        exp_q.push_back('{addr: 32'h0000_4440, data: l5});
        launch(32'h0000_4448, acc);
        do_fetch(32'h0000_4440, l5, 1, 1'b0);
        cycle();

        // 6: idle acks ignored, then refill across the top of memory
        bus.mem_rdata = 32'hFFFF_0000;
        bus.mem_ack   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("t6_idle_%0d", i), {bus.busy, bus.mem_rd}, 2'b00);
        end
        bus.mem_ack = 1'b0;
        check("t6_idle_data", bus.line_data, l5);
        check("t6_idle_addr", bus.line_addr, 32'h0000_4440);
        exp_q.push_back('{addr: 32'hFFFF_FFF0, data: l6});
        launch(32'hFFFF_FFF8, acc);
        do_fetch(32'hFFFF_FFF0, l6, 0, 1'b0);
        check("t6_line_valid", bus.line_valid, 1'b1);
        cycle(); cycle();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("lv_pulse_count", 32'(lv_pulses), 32'd5);
        check("err_pulse_count", 32'(err_pulses), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/icache_refill.md
# icache_refill

Refill engine that sits between the instruction cache and the word-wide instruction memory. On a cache miss it fetches the four consecutive 32-bit words of the missing 16-byte line, assembles them into the 128-bit line format the cache stores, and presents the line for one cycle. It is the memory-side responder to the cache's miss request. It also includes a watchdog that aborts a refill if memory stops acknowledging.

## Interface

Parameters:
- TIMEOUT, 255: maximum consecutive cycles without mem_ack during a fetch before the refill is aborted. Legal range 1..65535.

Ports:
- clock  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- miss_req  input  1  cache miss request; sampled only in IDLE
- miss_addr  input  32  PC of the missing instruction; low 4 bits ignored
- busy  output  1  high whenever the state is not IDLE
- line_data  output  128  assembled line; word k occupies bits [32k+31:32k]
- line_addr  output  32  line base address, {miss_addr[31:4], 4'b0}
- line_valid  output  1  one-cycle pulse when line_data and line_addr are complete
- refill_err  output  1  one-cycle pulse on watchdog abort
- mem_rd  output  1  read request to instruction memory
- mem_addr  output  32  word address being read
- mem_rdata  input  32  read data, valid when mem_ack=1
- mem_ack  input  1  memory acknowledge; one word per acknowledged cycle

## Operation

- State machine has three states: IDLE, FETCH, DONE.
- **IDLE**
  - If miss_req=1, latch base = {miss_addr[31:4], 4'b0} and set word counter k=0. Clear the watchdog and go to FETCH.
  - Otherwise stay in IDLE.
- **FETCH**
  - mem_rd=1 and mem_addr = base + 4k.
  - On mem_ack=1, write mem_rdata into line_data[32k+31:32k], increment k, and clear the watchdog.
  - If that ack was for k=3, go to DONE.
  - Without an ack, the watchdog increments.
  - When the watchdog reaches TIMEOUT, pulse refill_err and return to IDLE. line_valid is not asserted, and words already captured stay in line_data.
- **DONE**
  - line_valid=1 for exactly this cycle; line_addr = base.
  - Next state is IDLE.
- Word order is fixed at 0,1,2,3. There is no critical-word-first ordering.
- line_data and line_addr hold their values until overwritten by the next refill.
- mem_ack while mem_rd=0 is ignored.
- miss_req is ignored in FETCH and DONE. The cache must re-assert it after busy falls if it still misses.
- The watchdog counter is 16 bits wide and saturates at TIMEOUT. Address arithmetic wraps modulo 2^32; the base is always 16-byte aligned, so the line never crosses the wrap.

## Timing

- Reset values: state=IDLE, busy=0, line_valid=0, refill_err=0, mem_rd=0, mem_addr=0, line_data=0, line_addr=0, k=0, watchdog=0.
- Reset asserted mid-refill returns to IDLE on that edge. No line_valid or refill_err pulse is produced.
- Outputs are registered; mem_rd, mem_addr, busy, line_valid and refill_err all change only on clock edges.
- Fastest refill:
  - miss_req sampled at edge 0.
  - mem_rd=1 during cycles 1..4, with mem_ack on each.
  - line_valid=1 in cycle 5.
  - busy=0 and miss_req can be accepted again at the edge ending cycle 6.
- mem_addr advances in the cycle after each ack. mem_rd stays high continuously through FETCH, so back-to-back acks are legal.
- Wait states: each cycle without an ack in FETCH adds one cycle of latency.
- Abort timing: with no acks, refill_err pulses in the cycle after the TIMEOUT-th cycle without an ack. busy drops in that same cycle.

## Test plan

1. Basic refill:
   - Stimulus: reset, then miss_req=1 with miss_addr=0x0000_1234; memory acks every cycle with data 0xA0, 0xA1, 0xA2, 0xA3.
   - Required: mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C. line_valid pulses once, with line_addr=0x0000_1230 and line_data=0x000000A3_000000A2_000000A1_000000A0.
2. Wait states:
   - Stimulus: memory inserts 2 idle cycles before each ack.
   - Required: line_valid arrives 8 cycles later than in scenario 1. Data is correct and mem_addr holds steady through each wait.
3. Busy-ignore:
   - Stimulus: a second miss_req for 0x2000 pulsed during FETCH of 0x1230.
   - Required: exactly one line_valid, with line_addr=0x1230, and no fetch from 0x2000.
4. Watchdog:
   - Stimulus: TIMEOUT=4; memory acks word 0, then never acks again.
   - Required: refill_err pulses once, line_valid never asserts, busy returns to 0, and line_data[31:0] holds word 0.
5. Reset mid-op:
   - Stimulus: assert reset after the second ack.
   - Required: next cycle has busy=0, mem_rd=0 and line_data=0, with no pulses. A fresh miss then refills correctly.
6. Wrap and spurious ack:
   - Stimulus: miss_addr=0xFFFF_FFF8, plus mem_ack pulses while idle.
   - Required: addresses 0xFFFFFFF0..0xFFFFFFFC are fetched. The idle acks change no state.
